// File: rtl/ram_burst_ctrl.sv
// Burst access sequencer for a 512x16 synchronous RAM: turns one start pulse into a
// strided sequence of single-cycle RAM writes (fed by a valid/ready stream) or reads.
module ram_burst_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_read,
    output logic              ram_write,
    output logic              ram_en1,
    input  logic [DATA_W-1:0] ram_out
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                wr_ready_q, wr_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   ram_add_q, ram_add_d;
    logic [DATA_W-1:0]   ram_in_q, ram_in_d;
    logic                ram_read_q, ram_read_d;
    logic                ram_write_q, ram_write_d;
    logic                ram_en1_q, ram_en1_d;
    logic [RD_LAT-1:0]   vld_sr_q, vld_sr_d;

    // State and registered outputs; reset drops every RAM strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_add_q   <= '0;
            ram_in_q    <= '0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_en1_q   <= 1'b0;
            vld_sr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_add_q   <= ram_add_d;
            ram_in_q    <= ram_in_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            ram_en1_q   <= ram_en1_d;
            vld_sr_q    <= vld_sr_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        remaining_d = remaining_q;
        ram_add_d   = ram_add_q;
        ram_in_d    = ram_in_q;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        ram_en1_d   = 1'b0;

        // Tracks each read currently on the RAM pins until its data is due on ram_out.
        vld_sr_d    = '0;
        vld_sr_d[0] = ram_en1_q & ~ram_write_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    stride_d    = stride;
                    remaining_d = count;
                    if (count == '0) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid && wr_ready_q) begin
                    ram_add_d   = addr_q;
                    ram_in_d    = wr_data;
                    ram_read_d  = 1'b1;
                    ram_write_d = 1'b1;
                    ram_en1_d   = 1'b1;
                    addr_d      = addr_q + stride_q;
                    remaining_d = remaining_q - CNT_W'(1);
                end else if (remaining_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                ram_add_d   = addr_q;
                ram_read_d  = 1'b1;
                ram_en1_d   = 1'b1;
                addr_d      = addr_q + stride_q;
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!ram_en1_q && (vld_sr_d == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_ready_d = (state_d == S_WRITE) && (remaining_d != '0);
        busy_d     = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_add   = ram_add_q;
    assign ram_in    = ram_in_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_en1   = ram_en1_q;
    assign rd_valid  = vld_sr_q[RD_LAT-1];
    // Read data is the RAM output itself, qualified by rd_valid.
    assign rd_data   = ram_out;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: vector table of bursts against a behavioural
// 512x16 RAM with one cycle read latency, plus a hand-written mid-burst reset sequence.
module tb_ram_burst_ctrl;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_add;
    logic [DATA_W-1:0] ram_in;
    logic              ram_read;
    logic              ram_write;
    logic              ram_en1;
    logic [DATA_W-1:0] ram_out;

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    ram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .stride(stride), .count(count), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .done(done), .ram_add(ram_add), .ram_in(ram_in), .ram_read(ram_read),
        .ram_write(ram_write), .ram_en1(ram_en1), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_en1 && ram_write) begin
            mem[ram_add] <= ram_in;
        end else if (ram_en1 && ram_read) begin
            ram_out <= mem[ram_add];
        end
    end

    typedef struct {
        bit mode;
        int base;
        int stride;
        int count;
        bit toggle;
        bit restart;
        int exp_last;
        int exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int exp_addr[$];
        logic [DATA_W-1:0] rd_exp[$];
        int iss_cyc[$];
        int a, acc, rdn, cyc, done_cyc, wr_idx, last_addr;
        a = v.base;
        for (int i = 0; i < v.count; i++) begin
            exp_addr.push_back(a);
            a = (a + v.stride) % DEPTH;
        end
        acc = 0; rdn = 0; done_cyc = -1; wr_idx = 0; last_addr = -1;

        @(negedge clk);
        start     = 1'b1;
        mode      = v.mode;
        base_addr = ADDR_W'(v.base);
        stride    = ADDR_W'(v.stride);
        count     = (ADDR_W+1)'(v.count);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_after_start", busy, v.count != 0);

        while (done_cyc < 0 && cyc < v.count * 2 + 20) begin
            if (ram_en1) begin
                if (acc < v.count) begin
                    check("ram_add", ram_add, exp_addr[acc]);
                    check("ram_write", ram_write, v.mode);
                    check("ram_read", ram_read, 1);
                    if (v.mode) begin
                        check("ram_in", ram_in, exp_addr[acc]);
                        shadow[exp_addr[acc]] = DATA_W'(exp_addr[acc]);
                    end else begin
                        rd_exp.push_back(shadow[exp_addr[acc]]);
                        iss_cyc.push_back(cyc);
                    end
                end
                last_addr = int'(ram_add);
                acc++;
            end
            if (rd_valid) begin
                if (rd_exp.size() == 0) begin
                    check("rd_valid_unexpected", 1, 0);
                end else begin
                    check("rd_data", rd_data, rd_exp.pop_front());
                    check("rd_latency", cyc - iss_cyc.pop_front(), 1);
                end
                rdn++;
            end
            if (done) begin
                done_cyc = cyc;
                check("busy_in_done", busy, 0);
            end
            if (v.mode) begin
                wr_valid = v.toggle ? (cyc % 2 == 1) : 1'b1;
                if (wr_valid && wr_ready && wr_idx < v.count) begin
                    wr_data = DATA_W'(exp_addr[wr_idx]);
                    wr_idx++;
                end
            end
            if (v.restart && cyc == 3) begin
                start     = 1'b1;
                mode      = ~v.mode;
                base_addr = '0;
                count     = (ADDR_W+1)'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        start    = 1'b0;

        check("done_cycle", done_cyc, v.exp_done);
        check("access_count", acc, v.count);
        check("rd_beat_count", rdn, v.mode ? 0 : v.count);
        check("last_addr", last_addr, v.exp_last);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]    = 16'h5A00 ^ DATA_W'(i);
            shadow[i] = 16'h5A00 ^ DATA_W'(i);
        end
        ram_out   = '0;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        base_addr = '0;
        stride    = '0;
        count     = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;

        // mode, base, stride, count, toggle, restart, last address, done cycle
        vecs[0] = '{1'b1, 2,   64, 8,   1'b0, 1'b0, 450, 10};
        vecs[1] = '{1'b0, 2,   64, 8,   1'b0, 1'b1, 450, 11};
        vecs[2] = '{1'b0, 500, 20, 3,   1'b0, 1'b0, 28,  6};
        vecs[3] = '{1'b0, 7,   1,  0,   1'b0, 1'b0, -1,  1};
        vecs[4] = '{1'b1, 10,  3,  4,   1'b1, 1'b0, 19,  9};
        vecs[5] = '{1'b1, 510, 1,  4,   1'b0, 1'b0, 1,   6};
        vecs[6] = '{1'b0, 510, 1,  4,   1'b0, 1'b0, 1,   7};
        vecs[7] = '{1'b0, 5,   0,  512, 1'b0, 1'b0, 5,   515};

        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_en1", ram_en1, 0);
        check("rst_ram_add", ram_add, 0);
        check("rst_ram_in", ram_in, 0);
        check("rst_ram_rw", {ram_read, ram_write}, 0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_burst(vecs[k]);
        end

        // Reset on the third beat of an 8-beat read.
        begin
            int acc;
            int cyc;
            acc = 0;
            cyc = 0;
            @(negedge clk);
            start     = 1'b1;
            mode      = 1'b0;
            base_addr = ADDR_W'(2);
            stride    = ADDR_W'(64);
            count     = (ADDR_W+1)'(8);
            @(negedge clk);
            start = 1'b0;
            while (acc < 3 && cyc < 20) begin
                if (ram_en1) acc++;
                if (acc < 3) begin
                    @(negedge clk);
                    cyc++;
                end
            end
            check("rst_test_reached_beat3", acc, 3);
            rst = 1'b1;
            #1;
            check("midrst_en1", ram_en1, 0);
            check("midrst_rw", {ram_read, ram_write}, 0);
            check("midrst_busy", busy, 0);
            check("midrst_rd_valid", rd_valid, 0);
            check("midrst_ram_add", ram_add, 0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 8; i++) begin
                check("post_rst_quiet", {rd_valid, done, ram_en1, busy}, 0);
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
